// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: shares the single RAM/IO byte port between instruction
// fetch and load/store, splitting 1/2/4-byte requests and reassembling little-endian words.
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        IOWAIT = 2'd3
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  cap_q, cap_d;
    logic [2:0]  n_q, n_d;
    logic        fetch_q, fetch_d;
    logic        io_q, io_d;
    logic        a_vld_q, a_vld_d;
    logic        d_vld_q, d_vld_d;
    logic        stall_q;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        n_d        = n_q;
        fetch_d    = fetch_q;
        io_d       = io_q;
        a_vld_d    = a_vld_q;
        d_vld_d    = d_vld_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            IDLE: begin
                if (ls_req) begin
                    base_d  = ls_addr;
                    n_d     = size_bytes(ls_size);
                    fetch_d = 1'b0;
                    mem_a_d = ls_addr;
                    if (ls_we) begin
                        wdata_d = ls_wdata;
                        io_d    = (ls_addr[17:16] == 2'b11);
                        if ((ls_addr[17:16] == 2'b11) && io_buffer_full) begin
                            state_d = IOWAIT;
                            cnt_d   = 3'd0;
                        end else begin
                            state_d    = WRITE;
                            mem_dout_d = ls_wdata[7:0];
                            mem_wr_d   = 1'b1;
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        io_d    = 1'b0;
                        state_d = READ;
                        cnt_d   = 3'd1;
                        cap_d   = 3'd0;
                        buf_d   = 32'd0;
                        a_vld_d = 1'b1;
                        d_vld_d = 1'b0;
                    end
                end else if (if_req && !flush) begin
                    base_d  = if_addr;
                    n_d     = 3'd4;
                    fetch_d = 1'b1;
                    io_d    = 1'b0;
                    mem_a_d = if_addr;
                    state_d = READ;
                    cnt_d   = 3'd1;
                    cap_d   = 3'd0;
                    buf_d   = 32'd0;
                    a_vld_d = 1'b1;
                    d_vld_d = 1'b0;
                end
            end

            READ: begin
                if (fetch_q && flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    cap_d   = 3'd0;
                    a_vld_d = 1'b0;
                    d_vld_d = 1'b0;
                end else if (stall_q) begin
                    // mem_din now reflects the address held during the pause, so
                    // restart the pipeline from the first byte not yet captured.
                    mem_a_d = base_q + {29'd0, cap_q};
                    cnt_d   = cap_q + 3'd1;
                    a_vld_d = 1'b1;
                    d_vld_d = 1'b0;
                end else begin
                    d_vld_d = a_vld_q;
                    if (cnt_q < n_q) begin
                        mem_a_d = base_q + {29'd0, cnt_q};
                        cnt_d   = cnt_q + 3'd1;
                        a_vld_d = 1'b1;
                    end else begin
                        a_vld_d = 1'b0;
                    end
                    if (d_vld_q) begin
                        buf_d = byte_ins(buf_q, cap_q[1:0], mem_din);
                        cap_d = cap_q + 3'd1;
                        if ((cap_q + 3'd1) == n_q) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            cap_d   = 3'd0;
                            a_vld_d = 1'b0;
                            d_vld_d = 1'b0;
                            if (fetch_q) begin
                                if_done_d = 1'b1;
                                if_data_d = buf_d;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_d;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                if (cnt_q == n_q) begin
                    state_d   = IDLE;
                    ls_done_d = 1'b1;
                    cnt_d     = 3'd0;
                end else if (io_q && io_buffer_full) begin
                    state_d = IOWAIT;
                end else begin
                    mem_a_d    = base_q + {29'd0, cnt_q};
                    mem_dout_d = byte_sel(wdata_q, cnt_q[1:0]);
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            IOWAIT: begin
                if (!io_buffer_full) begin
                    state_d    = WRITE;
                    mem_a_d    = base_q + {29'd0, cnt_q};
                    mem_dout_d = byte_sel(wdata_q, cnt_q[1:0]);
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control and visible outputs; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            cap_q      <= 3'd0;
            n_q        <= 3'd0;
            fetch_q    <= 1'b0;
            io_q       <= 1'b0;
            a_vld_q    <= 1'b0;
            d_vld_q    <= 1'b0;
            stall_q    <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            stall_q <= !rdy_in;
            if (rdy_in) begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                cap_q      <= cap_d;
                n_q        <= n_d;
                fetch_q    <= fetch_d;
                io_q       <= io_d;
                a_vld_q    <= a_vld_d;
                d_vld_q    <= d_vld_d;
                mem_a_q    <= mem_a_d;
                mem_dout_q <= mem_dout_d;
                mem_wr_q   <= mem_wr_d;
                if_done_q  <= if_done_d;
                ls_done_q  <= ls_done_d;
                if_data_q  <= if_data_d;
                ls_rdata_q <= ls_rdata_d;
            end
        end
    end

    // Internal data holders are always loaded before use, so they need no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            base_q  <= base_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy_in;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: small RAM model with one-cycle read latency,
// one task per scenario, outputs sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int vectors = 0;
    int errors  = 0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_1002: return 8'h00;
            32'h0000_1003: return 8'h00;
            32'h0000_0020: return 8'hF0;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk_in) mem_din <= ram_byte(mem_a);

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        vectors++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h want %h", mem_a, 32'd0); end
        vectors++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got %h want %h", mem_dout, 8'd0); end
        vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        vectors++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", if_done); end
        vectors++; if (ls_done !== 1'b0) begin errors++; $display("FAIL reset_ls_done got %b want 0", ls_done); end
        vectors++; if (if_data !== 32'd0) begin errors++; $display("FAIL reset_if_data got %h want 0", if_data); end
        vectors++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset_ls_rdata got %h want 0", ls_rdata); end
        rst_in = 1'b0;
    endtask

    task automatic test_fetch();
        int pulses = 0;
        int pcyc = 0;
        logic [31:0] got = 32'd0;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            if (c == 1) if_req = 1'b0;
            if (c <= 4) begin
                vectors++;
                if (mem_a !== 32'h1000 + c - 1) begin
                    errors++; $display("FAIL fetch_addr cycle %0d got %h want %h", c, mem_a, 32'h1000 + c - 1);
                end
                vectors++;
                if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_no_wr cycle %0d got %b want 0", c, mem_wr); end
            end
            if (if_done) begin pulses++; pcyc = c; got = if_data; end
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL fetch_done_count got %0d want 1", pulses); end
        vectors++; if (pcyc != 6) begin errors++; $display("FAIL fetch_done_cycle got %0d want 6", pcyc); end
        vectors++; if (got !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data got %h want %h", got, 32'h0000_0513); end
    endtask

    task automatic test_arbitration();
        int ls_cyc = 0;
        int if_cyc = 0;
        logic [31:0] ls_got = 32'd0;
        logic [31:0] if_got = 32'd0;
        logic [31:0] a1 = 32'd0;
        logic [31:0] a4 = 32'd0;
        @(negedge clk_in);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_in);
            if (c == 1) a1 = mem_a;
            if (c == 4) a4 = mem_a;
            if (ls_done) begin ls_cyc = c; ls_got = ls_rdata; ls_req = 1'b0; end
            if (if_done) begin if_cyc = c; if_got = if_data; if_req = 1'b0; end
        end
        vectors++; if (a1 !== 32'h20) begin errors++; $display("FAIL arb_load_first got %h want %h", a1, 32'h20); end
        vectors++; if (ls_cyc != 3) begin errors++; $display("FAIL arb_ls_done_cycle got %0d want 3", ls_cyc); end
        vectors++; if (ls_got !== 32'h0000_00F0) begin errors++; $display("FAIL arb_ls_rdata got %h want %h", ls_got, 32'h0000_00F0); end
        vectors++; if (a4 !== 32'h1000) begin errors++; $display("FAIL arb_fetch_start got %h want %h", a4, 32'h1000); end
        vectors++; if (if_cyc != 9) begin errors++; $display("FAIL arb_if_done_cycle got %0d want 9", if_cyc); end
        vectors++; if (if_got !== 32'h0000_0513) begin errors++; $display("FAIL arb_if_data got %h want %h", if_got, 32'h0000_0513); end
    endtask

    task automatic test_store();
        logic [31:0] wd = 32'hDEADBEEF;
        logic [7:0]  exp_b;
        @(negedge clk_in);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h100; ls_wdata = wd;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            if (c == 1) ls_req = 1'b0;
            if (c <= 4) begin
                exp_b = wd[8*(c-1) +: 8];
                vectors++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL store_wr cycle %0d got %b want 1", c, mem_wr); end
                vectors++; if (mem_a !== 32'h100 + c - 1) begin errors++; $display("FAIL store_addr cycle %0d got %h want %h", c, mem_a, 32'h100 + c - 1); end
                vectors++; if (mem_dout !== exp_b) begin errors++; $display("FAIL store_data cycle %0d got %h want %h", c, mem_dout, exp_b); end
                vectors++; if (ls_done !== 1'b0) begin errors++; $display("FAIL store_early_done cycle %0d got %b want 0", c, ls_done); end
            end else if (c == 5) begin
                vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL store_wr_end got %b want 0", mem_wr); end
                vectors++; if (ls_done !== 1'b1) begin errors++; $display("FAIL store_done got %b want 1", ls_done); end
            end else begin
                vectors++; if (ls_done !== 1'b0) begin errors++; $display("FAIL store_done_pulse got %b want 0", ls_done); end
            end
        end
    endtask

    task automatic test_io_store();
        int wr_cnt = 0;
        int wr_cyc = 0;
        int done_cyc = 0;
        logic [31:0] wr_a = 32'd0;
        logic [7:0]  wr_d = 8'd0;
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            if (c == 1) ls_req = 1'b0;
            if (mem_wr) begin wr_cnt++; wr_cyc = c; wr_a = mem_a; wr_d = mem_dout; end
            if (ls_done) done_cyc = c;
            if (c == 3) io_buffer_full = 1'b0;
        end
        vectors++; if (wr_cnt != 1) begin errors++; $display("FAIL io_write_count got %0d want 1", wr_cnt); end
        vectors++; if (wr_cyc != 4) begin errors++; $display("FAIL io_write_cycle got %0d want 4", wr_cyc); end
        vectors++; if (wr_a !== 32'h0003_0000) begin errors++; $display("FAIL io_addr got %h want %h", wr_a, 32'h0003_0000); end
        vectors++; if (wr_d !== 8'h41) begin errors++; $display("FAIL io_data got %h want %h", wr_d, 8'h41); end
        vectors++; if (done_cyc != 5) begin errors++; $display("FAIL io_done_cycle got %0d want 5", done_cyc); end
    endtask

    task automatic test_flush();
        int if_pulses = 0;
        int ls_cyc = 0;
        logic [31:0] ls_got = 32'd0;
        logic [31:0] a6 = 32'd0;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (if_done) if_pulses++;
            if (ls_done) begin ls_cyc = c; ls_got = ls_rdata; end
            if (c == 6) a6 = mem_a;
            if (c == 4) begin
                flush = 1'b1; if_req = 1'b0;
                ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
            end
            if (c == 5) flush = 1'b0;
            if (c == 6) ls_req = 1'b0;
        end
        vectors++; if (if_pulses != 0) begin errors++; $display("FAIL flush_no_if_done got %0d want 0", if_pulses); end
        vectors++; if (a6 !== 32'h20) begin errors++; $display("FAIL flush_ls_accept got %h want %h", a6, 32'h20); end
        vectors++; if (ls_cyc != 8) begin errors++; $display("FAIL flush_ls_done_cycle got %0d want 8", ls_cyc); end
        vectors++; if (ls_got !== 32'h0000_00F0) begin errors++; $display("FAIL flush_ls_rdata got %h want %h", ls_got, 32'h0000_00F0); end
        vectors++; if (if_data !== 32'h0000_0513) begin errors++; $display("FAIL flush_if_data_held got %h want %h", if_data, 32'h0000_0513); end
    endtask

    task automatic test_pause();
        int pulses = 0;
        int pcyc = 0;
        int wr_seen = 0;
        logic [31:0] got = 32'd0;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h2000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (mem_wr) wr_seen++;
            if (if_done) begin pulses++; pcyc = c; got = if_data; end
            if (c == 1) if_req = 1'b0;
            if (c == 2) rdy_in = 1'b0;
            if (c == 4) rdy_in = 1'b1;
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL pause_done_count got %0d want 1", pulses); end
        vectors++; if (pcyc != 10) begin errors++; $display("FAIL pause_done_cycle got %0d want 10", pcyc); end
        vectors++; if (got !== 32'h5958_5B5A) begin errors++; $display("FAIL pause_data got %h want %h", got, 32'h5958_5B5A); end
        vectors++; if (wr_seen != 0) begin errors++; $display("FAIL pause_no_wr got %0d want 0", wr_seen); end
    endtask

    task automatic test_back_to_back();
        int d1 = 0;
        int d2 = 0;
        logic [31:0] g1 = 32'd0;
        logic [31:0] g2 = 32'd0;
        logic [31:0] a4 = 32'd0;
        logic [31:0] a5 = 32'd0;
        @(negedge clk_in);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (ls_done) begin
                if (d1 == 0) begin d1 = c; g1 = ls_rdata; end
                else begin d2 = c; g2 = ls_rdata; end
            end
            if (c == 4) a4 = mem_a;
            if (c == 5) a5 = mem_a;
            if (c == 3) begin ls_addr = 32'hFFFF_FFFF; ls_size = 2'd1; end
            if (c == 7) ls_req = 1'b0;
        end
        vectors++; if (d1 != 3) begin errors++; $display("FAIL b2b_first_done got %0d want 3", d1); end
        vectors++; if (g1 !== 32'h0000_00F0) begin errors++; $display("FAIL b2b_first_data got %h want %h", g1, 32'h0000_00F0); end
        vectors++; if (a4 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_addr0 got %h want %h", a4, 32'hFFFF_FFFF); end
        vectors++; if (a5 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got %h want %h", a5, 32'h0); end
        vectors++; if (d2 != 7) begin errors++; $display("FAIL b2b_second_done got %0d want 7", d2); end
        vectors++; if (g2 !== 32'h0000_5AA5) begin errors++; $display("FAIL wrap_data got %h want %h", g2, 32'h0000_5AA5); end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk_in);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            if (c == 1) ls_req = 1'b0;
            if (c == 2) begin
                vectors++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_store_active got %b want 1", mem_wr); end
                rst_in = 1'b1;
            end
            if (c == 3) begin
                vectors++; if (mem_a !== 32'd0) begin errors++; $display("FAIL rst_mid_mem_a got %h want 0", mem_a); end
                vectors++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL rst_mid_mem_dout got %h want 0", mem_dout); end
                vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_wr got %b want 0", mem_wr); end
                vectors++; if (ls_done !== 1'b0) begin errors++; $display("FAIL rst_mid_ls_done got %b want 0", ls_done); end
                vectors++; if (if_done !== 1'b0) begin errors++; $display("FAIL rst_mid_if_done got %b want 0", if_done); end
                vectors++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_ls_rdata got %h want 0", ls_rdata); end
                vectors++; if (if_data !== 32'd0) begin errors++; $display("FAIL rst_mid_if_data got %h want 0", if_data); end
                rst_in = 1'b0;
            end
            if (c >= 4) begin
                vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_idle_wr cycle %0d got %b want 0", c, mem_wr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store();
        test_io_store();
        test_flush();
        test_pause();
        test_back_to_back();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
